// File: rtl/mmu_csr_pkg.sv
// Translation-control CSR definitions shared by the MMU CSR unit.
// Addresses, field positions, reset value and register layouts.
package mmu_csr_pkg;

  localparam logic [13:0] CSR_CRMD = 14'h000;
  localparam logic [13:0] CSR_PRMD = 14'h001;
  localparam logic [13:0] CSR_DMW0 = 14'h180;
  localparam logic [13:0] CSR_DMW1 = 14'h181;

  localparam int CRMD_PLV_LSB  = 0;
  localparam int CRMD_IE_BIT   = 2;
  localparam int CRMD_DA_BIT   = 3;
  localparam int CRMD_PG_BIT   = 4;
  localparam int CRMD_DATF_LSB = 5;
  localparam int CRMD_DATM_LSB = 7;
  localparam int PRMD_PPLV_LSB = 0;
  localparam int PRMD_PIE_BIT  = 2;
  localparam int DMW_PLV0_BIT  = 0;
  localparam int DMW_PLV3_BIT  = 3;
  localparam int DMW_MAT_LSB   = 4;
  localparam int DMW_PSEG_LSB  = 25;
  localparam int DMW_VSEG_LSB  = 29;

  localparam logic [31:0] CRMD_RST  = 32'h0000_0008;
  localparam logic [31:0] CRMD_IMPL = 32'h0000_01FF;
  localparam logic [31:0] PRMD_IMPL = 32'h0000_0007;
  localparam logic [31:0] DMW_IMPL  = 32'hEE00_0039;

  typedef struct packed {
    logic [22:0] rsv;
    logic [1:0]  datm;
    logic [1:0]  datf;
    logic        pg;
    logic        da;
    logic        ie;
    logic [1:0]  plv;
  } crmd_t;

  typedef struct packed {
    logic [28:0] rsv;
    logic        pie;
    logic [1:0]  pplv;
  } prmd_t;

  typedef struct packed {
    logic [2:0]  vseg;
    logic        rsv28;
    logic [2:0]  pseg;
    logic [18:0] rsv24;
    logic [1:0]  mat;
    logic        plv3;
    logic [1:0]  rsv2;
    logic        plv0;
  } dmw_t;

endpackage

// File: rtl/csr_mask_merge.sv
// Masked CSR write merge: keeps old bits outside the mask,
// takes write data inside it, and zeroes unimplemented bits.
module csr_mask_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] wmask_i,
  input  logic [31:0] impl_i,
  output logic [31:0] new_o
);

  assign new_o = ((old_i & ~wmask_i) | (wdata_i & wmask_i)) & impl_i;

endmodule

// File: rtl/mmu_csr_unit.sv
// Translation-control CSRs (CRMD, PRMD, DMW0/1) feeding the data translator.
// Define MMU_CSR_DMW1_EN to implement the second direct-mapping window.
module mmu_csr_unit
  import mmu_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] csr_raddr,
  output logic [31:0] csr_rdata,
  input  logic        csr_we,
  input  logic [13:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] csr_wmask,
  input  logic        exc_valid,
  input  logic        ertn_valid,
  output logic [1:0]  plv,
  output logic [1:0]  translate_mode,
  output logic [1:0]  direct_d_mat,
  output logic        dmw0_plv0,
  output logic        dmw0_plv3,
  output logic        dmw1_plv0,
  output logic        dmw1_plv3,
  output logic [1:0]  dmw0_mat,
  output logic [1:0]  dmw1_mat,
  output logic [2:0]  dmw0_vseg,
  output logic [2:0]  dmw0_pseg,
  output logic [2:0]  dmw1_vseg,
  output logic [2:0]  dmw1_pseg,
  output logic        cfg_flush
);

  crmd_t crmd_q, crmd_d;
  prmd_t prmd_q, prmd_d;
  dmw_t  dmw0_q, dmw0_d;
  dmw_t  dmw1_q, dmw1_d;
  logic  flush_q, flush_d;

  logic [31:0] crmd_m, prmd_m, dmw0_m;

  csr_mask_merge u_mm_crmd (
    .old_i   (crmd_q),
    .wdata_i (csr_wdata),
    .wmask_i (csr_wmask),
    .impl_i  (CRMD_IMPL),
    .new_o   (crmd_m)
  );

  csr_mask_merge u_mm_prmd (
    .old_i   (prmd_q),
    .wdata_i (csr_wdata),
    .wmask_i (csr_wmask),
    .impl_i  (PRMD_IMPL),
    .new_o   (prmd_m)
  );

  csr_mask_merge u_mm_dmw0 (
    .old_i   (dmw0_q),
    .wdata_i (csr_wdata),
    .wmask_i (csr_wmask),
    .impl_i  (DMW_IMPL),
    .new_o   (dmw0_m)
  );

`ifdef MMU_CSR_DMW1_EN
  logic [31:0] dmw1_m;

  csr_mask_merge u_mm_dmw1 (
    .old_i   (dmw1_q),
    .wdata_i (csr_wdata),
    .wmask_i (csr_wmask),
    .impl_i  (DMW_IMPL),
    .new_o   (dmw1_m)
  );
`endif

  // Next-state: exception beats ertn beats CSR write; one event per cycle.
  always_comb begin
    crmd_d = crmd_q;
    prmd_d = prmd_q;
    dmw0_d = dmw0_q;
    dmw1_d = dmw1_q;
    if (exc_valid) begin
      prmd_d.pplv = crmd_q.plv;
      prmd_d.pie  = crmd_q.ie;
      crmd_d.plv  = 2'b00;
      crmd_d.ie   = 1'b0;
    end else if (ertn_valid) begin
      crmd_d.plv = prmd_q.pplv;
      crmd_d.ie  = prmd_q.pie;
    end else if (csr_we) begin
      unique case (csr_waddr)
        CSR_CRMD: crmd_d = crmd_m;
        CSR_PRMD: prmd_d = prmd_m;
        CSR_DMW0: dmw0_d = dmw0_m;
`ifdef MMU_CSR_DMW1_EN
        CSR_DMW1: dmw1_d = dmw1_m;
`endif
        default: ;
      endcase
    end
`ifndef MMU_CSR_DMW1_EN
    dmw1_d = '0;
`endif
  end

  // Flush when any translator-visible field would change this cycle.
  always_comb begin
    flush_d =
      ({crmd_d.plv, crmd_d.pg, crmd_d.da, crmd_d.datm}
       != {crmd_q.plv, crmd_q.pg, crmd_q.da, crmd_q.datm})
      || ({dmw0_d.vseg, dmw0_d.pseg, dmw0_d.mat, dmw0_d.plv3, dmw0_d.plv0}
       != {dmw0_q.vseg, dmw0_q.pseg, dmw0_q.mat, dmw0_q.plv3, dmw0_q.plv0})
      || ({dmw1_d.vseg, dmw1_d.pseg, dmw1_d.mat, dmw1_d.plv3, dmw1_d.plv0}
       != {dmw1_q.vseg, dmw1_q.pseg, dmw1_q.mat, dmw1_q.plv3, dmw1_q.plv0});
  end

  // CSR state and flush pulse register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      crmd_q  <= CRMD_RST;
      prmd_q  <= '0;
      dmw0_q  <= '0;
      dmw1_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      crmd_q  <= crmd_d;
      prmd_q  <= prmd_d;
      dmw0_q  <= dmw0_d;
      dmw1_q  <= dmw1_d;
      flush_q <= flush_d;
    end
  end

  // Combinational readback of current register contents.
  always_comb begin
    csr_rdata = '0;
    unique case (csr_raddr)
      CSR_CRMD: csr_rdata = crmd_q;
      CSR_PRMD: csr_rdata = prmd_q;
      CSR_DMW0: csr_rdata = dmw0_q;
      CSR_DMW1: csr_rdata = dmw1_q;
      default:  csr_rdata = '0;
    endcase
  end

  assign plv            = crmd_q.plv;
  assign translate_mode = {crmd_q.pg, crmd_q.da};
  assign direct_d_mat   = crmd_q.datm;
  assign dmw0_plv0      = dmw0_q.plv0;
  assign dmw0_plv3      = dmw0_q.plv3;
  assign dmw0_mat       = dmw0_q.mat;
  assign dmw0_vseg      = dmw0_q.vseg;
  assign dmw0_pseg      = dmw0_q.pseg;
  assign dmw1_plv0      = dmw1_q.plv0;
  assign dmw1_plv3      = dmw1_q.plv3;
  assign dmw1_mat       = dmw1_q.mat;
  assign dmw1_vseg      = dmw1_q.vseg;
  assign dmw1_pseg      = dmw1_q.pseg;
  assign cfg_flush      = flush_q;

endmodule

// File: doc/mmu_csr_unit.md
# mmu_csr_unit

Holds the translation-control CSRs (CRMD, PRMD, DMW0, DMW1) and drives the configuration inputs of the data-side address translator: current privilege level, direct/paged mode, direct-mode memory type and both direct-mapping windows. It sits in the commit stage alongside the CSR file. It applies csrwr/csrxchg writes, exception entry and ertn in one cycle each. It pulses a flush request whenever a translation-relevant field changes, so in-flight accesses translated under the old configuration are discarded.

## Interface
- No parameters.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- csr_raddr  in  14  read address
- csr_rdata  out  32  read data (combinational)
- csr_we  in  1  write strobe, committed instruction
- csr_waddr  in  14  write address
- csr_wdata  in  32  write data
- csr_wmask  in  32  bit mask (all ones for csrwr, rj for csrxchg)
- exc_valid  in  1  exception entry commits this cycle
- ertn_valid  in  1  ertn commits this cycle
- plv  out  2  CRMD.PLV
- translate_mode  out  2  {CRMD.PG, CRMD.DA}; 01 direct, 10 paged
- direct_d_mat  out  2  CRMD.DATM
- dmw0_plv0, dmw0_plv3, dmw1_plv0, dmw1_plv3  out  1 each  window privilege enables
- dmw0_mat, dmw1_mat  out  2 each  window memory type
- dmw0_vseg, dmw0_pseg, dmw1_vseg, dmw1_pseg  out  3 each  window segments
- cfg_flush  out  1  one-cycle pulse: translation configuration changed

## Operation
- Addresses: CRMD 0x000, PRMD 0x001, DMW0 0x180, DMW1 0x181. Any other address reads 0 and ignores writes.
- Field layout:
  - CRMD: PLV[1:0], IE[2], DA[3], PG[4], DATF[6:5], DATM[8:7].
  - PRMD: PPLV[1:0], PIE[2].
  - DMWn: PLV0[0], PLV3[3], MAT[5:4], PSEG[27:25], VSEG[31:29].
  - Reserved bits read 0 and are not stored.
- Write: new = (old & ~csr_wmask) | (csr_wdata & csr_wmask), applied per implemented field.
- Exception entry: PRMD.PPLV←CRMD.PLV, PRMD.PIE←CRMD.IE, CRMD.PLV←0, CRMD.IE←0. DA/PG unchanged.
- ertn: CRMD.PLV←PRMD.PPLV, CRMD.IE←PRMD.PIE. PRMD unchanged.
- Same-cycle priority is exc_valid > ertn_valid > csr_we. A lower-priority event in the same cycle is dropped entirely.
- DA/PG are stored as written. An illegal pair (00/11) passes through on translate_mode, and the translator falls back to identity mapping.
- The cycle-N update sets a change flag when any bit of plv, translate_mode, direct_d_mat or the DMW output fields differs from its previous value. cfg_flush is that flag registered. Writes to IE, DATF or PRMD alone do not flush.
- Reset values:
  - CRMD = 0x0000_0008 (PLV 0, DA 1, PG 0, DATM 00).
  - PRMD, DMW0, DMW1 = 0.
  - cfg_flush = 0.

## Timing
- All state updates occur on the rising clk edge of the commit cycle. Outputs reflect the new value from cycle N+1.
- csr_rdata is combinational from the current registers, with no write-forwarding. A read and a write to the same address in cycle N return the pre-write value.
- cfg_flush is high for exactly cycle N+1 after a changing update. Back-to-back changing updates give consecutive pulses.
- Latency from event to output is 1 cycle. No backpressure and no stall.
- rst has priority over every event. Asserting rst mid-sequence restores reset values on the next edge, and cfg_flush is 0 during and after reset.

## Configuration
- MMU_CSR_DMW1_EN defined: DMW1 is implemented as above.
- MMU_CSR_DMW1_EN undefined:
  - No DMW1 storage.
  - Address 0x181 reads 0 and ignores writes.
  - All dmw1_* outputs are tied to 0.
  - DMW1 never contributes to cfg_flush.

## Structure
- Package mmu_csr_pkg holds:
  - CSR address constants.
  - Field bit-position constants.
  - CRMD reset value.
  - A packed struct typedef per register (crmd_t, prmd_t, dmw_t).
- Sub-module csr_mask_merge (old, wdata, wmask, implemented-bit mask → new) is instantiated once per register.
- All other logic is flat in mmu_csr_unit.

## Test plan
- Reset → plv=00, translate_mode=01, direct_d_mat=00, all dmw* = 0, cfg_flush=0, read 0x000 returns 0x0000_0008.
- csrwr DMW0 = 0xA000_0011 → next cycle dmw0_vseg=101, dmw0_pseg=000, dmw0_mat=01, dmw0_plv0=1, cfg_flush pulses once; readback 0xA000_0011.
- csrxchg CRMD with wdata 0x10, mask 0x18 → translate_mode=10, cfg_flush pulses; second identical write → no pulse.
- CRMD.PLV=3, IE=1, then exc_valid → plv=00, PRMD read 0x7, cfg_flush pulses; then ertn_valid → plv=11, CRMD.IE=1.
- exc_valid, ertn_valid and csr_we (CRMD PLV=3) in the same cycle → only the exception applies, plv=00.
- Write DMW1 = 0x2000_0009 with MMU_CSR_DMW1_EN undefined → read 0x181 returns 0, dmw1_* stay 0, no cfg_flush; with the macro defined → dmw1_vseg=001, dmw1_plv3=1, dmw1_plv0=1.
